// File: rtl/sram_fifo_ctrl.sv
// FIFO controller in front of a single-port synchronous SRAM with a one-word output register.
// SRAM reads have strict priority over writes; read data is captured the cycle after issue.
module sram_fifo_ctrl #(
    parameter int unsigned DATA_BW = 160,
    parameter int unsigned ADDR_BW = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BW-1:0]   in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_BW-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sram_cen,
    output logic                 sram_wen,
    output logic [ADDR_BW-1:0]   sram_a,
    output logic [DATA_BW-1:0]   sram_d,
    input  logic [DATA_BW-1:0]   sram_q,
    output logic [ADDR_BW:0]     occupancy
);

    localparam int unsigned CNT_BW = ADDR_BW + 1;
    localparam logic [CNT_BW-1:0] DEPTH = CNT_BW'(1 << ADDR_BW);

    logic [ADDR_BW-1:0] wr_ptr;
    logic [ADDR_BW-1:0] rd_ptr;
    logic [CNT_BW-1:0]  mem_count;
    logic               rd_pending;
    logic               rd_issue;
    logic               push;
    logic               pop;

    // Handshakes and SRAM port steering; a read issue blocks the write port for the cycle.
    always_comb begin
        rd_issue = !reset && (mem_count != '0) && !rd_pending && (!out_valid || out_ready);
        in_ready = !reset && (mem_count != DEPTH) && !rd_issue;
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        sram_cen = 1'b1;
        sram_wen = 1'b1;
        sram_a   = rd_ptr;
        if (rd_issue) begin
            sram_cen = 1'b0;
        end else if (push) begin
            sram_cen = 1'b0;
            sram_wen = 1'b0;
            sram_a   = wr_ptr;
        end
    end

    assign sram_d    = in_data;
    assign occupancy = mem_count + CNT_BW'(rd_pending) + CNT_BW'(out_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_count  <= '0;
            rd_pending <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            if (rd_issue) begin
                rd_ptr    <= rd_ptr + ADDR_BW'(1);
                mem_count <= mem_count - CNT_BW'(1);
            end else if (push) begin
                wr_ptr    <= wr_ptr + ADDR_BW'(1);
                mem_count <= mem_count + CNT_BW'(1);
            end
            rd_pending <= rd_issue;
            // A pending read always lands in an empty output register, so load wins over pop.
            if (rd_pending) begin
                out_data  <= sram_q;
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
